// File: rtl/symbol_pkg.sv
// Shared line-symbol codes and packer FSM states for the symbol packer slice.
package symbol_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO    = 2'b00,
        SYM_ILLEGAL = 2'b01,
        SYM_ONE     = 2'b10,
        SYM_MARK    = 2'b11
    } sym_e;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_PACK = 1'b1
    } state_e;

endpackage

// File: rtl/packer_outreg.sv
// Output holding register: presents completed payloads with a valid/ready
// handshake and flags a sticky overflow when a payload has nowhere to go.
module packer_outreg
    import symbol_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] load_data,
    input  logic             ready,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             ovf
);

    logic [NBITS-1:0] data_r, data_s;
    logic             valid_r, valid_s;
    logic             ovf_r, ovf_s;
    logic             stall_s;

    // A held payload that is not being consumed blocks a new one from landing.
    assign stall_s = valid_r & ~ready;

    // Next-state for the holding register, valid flag and sticky overflow.
    always_comb begin
        data_s  = data_r;
        valid_s = valid_r;
        ovf_s   = ovf_r;
        if (load) begin
            if (stall_s) begin
                ovf_s = 1'b1;
            end else begin
                data_s  = load_data;
                valid_s = 1'b1;
            end
        end else if (valid_r & ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= {NBITS{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            data_r  <= data_s;
            valid_r <= valid_s;
            ovf_r   <= ovf_s;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/symbol_packer.sv
// Packs MARK-framed 2-bit line symbols into NBITS payloads (MSB first) and
// counts framing errors with a saturating counter.
module symbol_packer
    import symbol_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in,
    output logic [NBITS-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             ovf,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    state_e           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [NBITS-1:0] shift_r, shift_s;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_s;
    logic [NBITS-1:0] payload_s;
    logic             done_s;
    logic             err_hit_s;
    sym_e             sym_s;

    assign sym_s     = sym_e'(in);
    assign payload_s = {shift_r[NBITS-2:0], in[1]};

    // Framing FSM: next state, bit counter, shift register and event strobes.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        done_s    = 1'b0;
        err_hit_s = 1'b0;
        case (state_r)
            ST_HUNT: begin
                case (sym_s)
                    SYM_MARK: begin
                        state_s = ST_PACK;
                        cnt_s   = {CNT_W{1'b0}};
                        shift_s = {NBITS{1'b0}};
                    end
                    SYM_ILLEGAL: err_hit_s = 1'b1;
                    default:     state_s   = ST_HUNT;
                endcase
            end
            ST_PACK: begin
                case (sym_s)
                    SYM_ZERO, SYM_ONE: begin
                        if (cnt_r == LAST_IDX) begin
                            // Completed payload is handed off straight from payload_s.
                            done_s  = 1'b1;
                            state_s = ST_HUNT;
                            cnt_s   = {CNT_W{1'b0}};
                            shift_s = {NBITS{1'b0}};
                        end else begin
                            shift_s = payload_s;
                            cnt_s   = cnt_r + CNT_W'(1);
                        end
                    end
                    SYM_MARK: begin
                        err_hit_s = 1'b1;
                        cnt_s     = {CNT_W{1'b0}};
                        shift_s   = {NBITS{1'b0}};
                    end
                    SYM_ILLEGAL: begin
                        err_hit_s = 1'b1;
                        state_s   = ST_HUNT;
                        cnt_s     = {CNT_W{1'b0}};
                        shift_s   = {NBITS{1'b0}};
                    end
                    default: state_s = ST_HUNT;
                endcase
            end
            default: state_s = ST_HUNT;
        endcase
    end

    // Saturating error counter next value.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (err_hit_s && (err_cnt_r != {ERR_W{1'b1}})) begin
            err_cnt_s = err_cnt_r + ERR_W'(1);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // FSM, shift register and error counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_HUNT;
            cnt_r     <= {CNT_W{1'b0}};
            shift_r   <= {NBITS{1'b0}};
            err_cnt_r <= {ERR_W{1'b0}};
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            shift_r   <= shift_s;
            err_cnt_r <= err_cnt_s;
        end
    end

    assign err_cnt = err_cnt_r;

    packer_outreg #(
        .NBITS(NBITS)
    ) u_outreg (
        .clk      (clk),
        .reset    (reset),
        .load     (done_s),
        .load_data(payload_s),
        .ready    (ready),
        .data     (data),
        .valid    (valid),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_symbol_packer.sv
// Directed plus randomized bench for symbol_packer, checked each cycle
// against a bit-queue reference model of the framing rules.
module tb_symbol_packer;

    localparam int NB = 8;
    localparam int EW = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk;
    logic          reset;
    logic [1:0]    in_s;
    logic [NB-1:0] data;
    logic          valid;
    logic          ready;
    logic          ovf;
    logic [EW-1:0] err_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit            m_in_frame;
    bit            mq[$];
    logic [NB-1:0] m_data;
    bit            m_valid;
    bit            m_ovf;
    int            m_err;

    symbol_packer #(.NBITS(NB), .ERR_W(EW)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_s),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .ovf    (ovf),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [1:0] sym, input logic rdy, input logic rst);
        bit            done;
        logic [NB-1:0] p;
        done = 1'b0;
        p    = '0;
        if (rst) begin
            m_in_frame = 1'b0;
            mq.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_err   = 0;
        end else begin
            if (sym == 2'b11) begin
                if (m_in_frame && m_err < ERR_MAX) m_err++;
                m_in_frame = 1'b1;
                mq.delete();
            end else if (sym == 2'b01) begin
                if (m_err < ERR_MAX) m_err++;
                m_in_frame = 1'b0;
                mq.delete();
            end else if (m_in_frame) begin
                mq.push_back(sym[1]);
                if (mq.size() == NB) begin
                    foreach (mq[i]) p = {p[NB-2:0], mq[i]};
                    done = 1'b1;
                    m_in_frame = 1'b0;
                    mq.delete();
                end
            end
            if (done) begin
                if (m_valid && !rdy) m_ovf = 1'b1;
                else begin
                    m_data  = p;
                    m_valid = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [1:0] sym, input logic rdy, input logic rst);
        in_s  = sym;
        ready = rdy;
        reset = rst;
        model_update(sym, rdy, rst);
        @(posedge clk);
        #1;
        chk("data", 32'(data), 32'(m_data));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
    endtask

    // Sends n bits of v, MSB first; rdy for all but the last, rdy_last for the last.
    task automatic send_bits(input logic [15:0] v, input int n, input logic rdy, input logic rdy_last);
        for (int i = n - 1; i >= 0; i--) begin
            step(v[i] ? 2'b10 : 2'b00, (i == 0) ? rdy_last : rdy, 1'b0);
        end
    endtask

    initial begin
        int r;
        logic [1:0] sym;
        in_s  = 2'b00;
        ready = 1'b0;
        reset = 1'b1;
        m_in_frame = 1'b0;
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_err = 0;

        // Reset values, including an upstream flush of 00 symbols
        step(2'b00, 1'b0, 1'b1);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b0);
        chk("flush_valid", 32'(valid), 32'h0);

        // Basic frame B2 with ready high
        step(2'b11, 1'b1, 1'b0);
        send_bits(16'hB2, 8, 1'b1, 1'b1);
        chk("b2_data", 32'(data), 32'hB2);
        chk("b2_valid", 32'(valid), 32'h1);
        step(2'b00, 1'b1, 1'b0);
        chk("b2_valid_low", 32'(valid), 32'h0);

        // Back-to-back frames with ready low: second dropped
        do_reset();
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'h3C, 8, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'hC3, 8, 1'b0, 1'b0);
        chk("ovf_data", 32'(data), 32'h3C);
        chk("ovf_flag", 32'(ovf), 32'h1);
        chk("ovf_err", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b0);
        chk("ovf_sticky", 32'(ovf), 32'h1);

        // Completion in the same cycle as a handshake
        do_reset();
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'h81, 8, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'h7E, 8, 1'b0, 1'b1);
        chk("hs_data", 32'(data), 32'h7E);
        chk("hs_valid", 32'(valid), 32'h1);
        chk("hs_ovf", 32'(ovf), 32'h0);

        // Resync MARK mid-frame
        do_reset();
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'h5, 3, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        send_bits(16'hFF, 8, 1'b0, 1'b0);
        chk("resync_err", 32'(err_cnt), 32'h1);
        chk("resync_data", 32'(data), 32'hFF);

        // ILLEGAL in PACK then saturation; bits afterwards are ignored in HUNT
        do_reset();
        step(2'b11, 1'b1, 1'b0);
        send_bits(16'h2, 2, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(2'b01, 1'b1, 1'b0);
        chk("sat_err", 32'(err_cnt), 32'hFF);
        send_bits(16'hA5, 8, 1'b1, 1'b1);
        chk("hunt_valid", 32'(valid), 32'h0);

        // Reset mid-frame then a clean frame
        do_reset();
        step(2'b11, 1'b1, 1'b0);
        send_bits(16'h1F, 5, 1'b1, 1'b1);
        do_reset();
        step(2'b11, 1'b1, 1'b0);
        send_bits(16'h5A, 8, 1'b1, 1'b1);
        chk("mid_rst_data", 32'(data), 32'h5A);
        chk("mid_rst_valid", 32'(valid), 32'h1);
        step(2'b00, 1'b1, 1'b0);
        chk("mid_rst_flags", 32'({valid, ovf}), 32'h0);
        chk("mid_rst_err", 32'(err_cnt), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 8)       sym = 2'b00;
            else if (r < 16) sym = 2'b10;
            else if (r < 19) sym = 2'b11;
            else             sym = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
            step(sym, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/symbol_packer.md
SYMBOL_PACKER -- requirements
Module: symbol_packer

Interface
REQ-001 Parameter NBITS, default 8: payload bits per frame (2..16).
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in  input  2  line symbol from upstream 4-stage buffer, one per cycle.
REQ-006 data  output  NBITS  assembled payload, MSB = first received bit.
REQ-007 valid  output  1  data holds an unconsumed payload.
REQ-008 ready  input  1  consumer accepts data when valid and ready are both high.
REQ-009 ovf  output  1  sticky overflow: a completed payload was dropped.
REQ-010 err_cnt  output  ERR_W  count of framing errors, saturating.

Function
REQ-011 Symbol codes SHALL be: 2'b00 = bit 0, 2'b10 = bit 1, 2'b11 = MARK, 2'b01 = ILLEGAL.
REQ-012 FSM SHALL have states HUNT and PACK; HUNT ignores 00/10 symbols.
REQ-013 HUNT + MARK -> PACK, bit counter cleared to 0, shift register cleared.
REQ-014 PACK + 00/10 SHALL shift bit in[1] into the LSB of the shift register and increment the bit counter.
REQ-015 When the NBITS-th bit is shifted, the payload SHALL be complete in that same cycle and the FSM SHALL return to HUNT.
REQ-016 PACK + MARK before completion SHALL discard the partial payload, increment err_cnt, clear the counter and stay in PACK (resync).
REQ-017 ILLEGAL in any state SHALL increment err_cnt; in PACK it SHALL also discard the partial payload and go to HUNT.
REQ-018 err_cnt SHALL saturate at 2^ERR_W-1, never wrap.
REQ-019 A completed payload SHALL appear on data with valid high on the cycle after the last bit is sampled (latency 1 from last bit).
REQ-020 A handshake (valid & ready) SHALL clear valid on the next cycle unless a new payload completes that same cycle.
REQ-021 Payload completion with valid high and ready low SHALL drop the new payload, keep data unchanged and set ovf.
REQ-022 Payload completion in the same cycle as a handshake SHALL load the new payload, keep valid high and not set ovf.
REQ-023 data SHALL stay stable while valid is high and ready is low.
REQ-024 ovf SHALL stay set until reset.

Reset
REQ-025 Reset SHALL force state HUNT, counter 0, shift register 0, data 0, valid 0, ovf 0, err_cnt 0.
REQ-026 Reset mid-frame SHALL discard the partial payload and any pending output; reset has priority over all events.
REQ-027 Upstream 00 symbols during its post-reset flush SHALL be harmless (treated as HUNT idle).

Structure
REQ-028 Symbol codes and the state enum SHALL live in a shared package symbol_pkg.
REQ-029 The output holding register with valid/ready/ovf logic SHALL be one sub-module, packer_outreg; the FSM, shift register and error counter stay in symbol_packer.

Verification
REQ-030 Reset, then MARK, 10,00,10,10,00,00,10,00 with ready=1 -> data=8'hB2, valid high one cycle after the 8th bit, then low.
REQ-031 Two back-to-back frames, ready=0 -> first payload held stable, second dropped, ovf=1, err_cnt=0.
REQ-032 Frame completing in the same cycle ready=1 consumes the previous payload -> new payload loaded, valid stays 1, ovf=0.
REQ-033 MARK, three bits, MARK, eight bits 8'hFF -> err_cnt=1, data=8'hFF.
REQ-034 ILLEGAL in PACK, then 300 ILLEGALs -> FSM in HUNT, err_cnt=255 (saturated).
REQ-035 Reset asserted after five bits of a frame, released, then full frame 8'h5A -> only 8'h5A delivered, all flags 0.
